// File: rtl/pll_reconfig_pkg.sv
// Shared types and constants for the video PLL reconfiguration sequencer.
package pll_reconfig_pkg;

    // Sequencer states: one state per Avalon-MM write, then the relock wait.
    typedef enum logic [2:0] {
        IDLE,
        WR_MODE,
        WR_K,
        WR_START,
        WAIT_LOCK
    } state_t;

    // Reconfig controller register map (word addresses).
    localparam logic [5:0] REG_MODE  = 6'd0;
    localparam logic [5:0] REG_START = 6'd2;
    localparam logic [5:0] REG_K     = 6'd7;

    // Mode register value 0 selects waitrequest mode in the controller.
    localparam logic [31:0] MODE_WAITREQ = 32'd0;

    // Fractional-K words for native timing and the 60 Hz overclock.
    localparam logic [31:0] K_NATIVE_DEFAULT  = 32'd2748778984;
    localparam logic [31:0] K_OVERCLK_DEFAULT = 32'd3221912667;

    // Pick the fractional-K word that belongs to a requested mode.
    function automatic logic [31:0] k_for_mode(input logic        mode,
                                               input logic [31:0] k_native,
                                               input logic [31:0] k_overclk);
        return mode ? k_overclk : k_native;
    endfunction

endpackage

// File: rtl/pll_reconfig_seq_sync_filter.sv
// Two-flop synchronizer followed by an optional stability filter.
// With STABLE_CYCLES = 0 the filter is bypassed and the output is the
// plain synchronized value; otherwise the output only follows the
// synchronized value once it has been seen unchanged STABLE_CYCLES times.
module sync_filter #(
    parameter int STABLE_CYCLES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    logic [1:0] sync_reg;

    // Two-stage synchronizer; sync_reg[1] is the metastability-safe copy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], din};
        end
    end

    generate
        if (STABLE_CYCLES == 0) begin : g_bypass
            assign dout = sync_reg[1];
        end else begin : g_filter
            logic       prev_reg;
            logic [3:0] run_reg;
            logic       out_reg;
            logic [4:0] run_next;

            // Length of the current run of identical samples, counting this one.
            always_comb begin
                run_next = 5'd1;
                if (sync_reg[1] == prev_reg) begin
                    run_next = {1'b0, run_reg} + 5'd1;
                end
            end

            // Track the run length (saturating) and accept a value once its run is long enough.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    prev_reg <= 1'b0;
                    run_reg  <= 4'd0;
                    out_reg  <= 1'b0;
                end else begin
                    prev_reg <= sync_reg[1];
                    run_reg  <= (run_next > 5'd15) ? 4'd15 : run_next[3:0];
                    if (run_next >= 5'(STABLE_CYCLES)) begin
                        out_reg <= sync_reg[1];
                    end
                end
            end

            assign dout = out_reg;
        end
    endgenerate

endmodule

// File: rtl/pll_reconfig_seq.sv
// Video PLL reconfiguration sequencer: filters the OSD game-speed request,
// issues the mode / fractional-K / start writes to the reconfig controller,
// then holds the game core in reset until the PLL relocks or times out.
module pll_reconfig_seq
    import pll_reconfig_pkg::*;
#(
    parameter logic [31:0] K_NATIVE      = K_NATIVE_DEFAULT,
    parameter logic [31:0] K_OVERCLK     = K_OVERCLK_DEFAULT,
    parameter int          STABLE_CYCLES = 2,
    parameter int          SETTLE_CYCLES = 16,
    parameter int          LOCK_TIMEOUT  = 65535
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mode_req,
    input  logic        pll_locked,
    input  logic        cfg_waitrequest,
    output logic        cfg_write,
    output logic [5:0]  cfg_address,
    output logic [31:0] cfg_data,
    output logic        busy,
    output logic        core_hold,
    output logic        applied_mode,
    output logic        lock_err
);

    localparam logic [15:0] SETTLE_C  = 16'(SETTLE_CYCLES);
    localparam logic [15:0] TIMEOUT_C = 16'(LOCK_TIMEOUT);

    state_t      state_reg;
    logic        target_reg;
    logic        applied_reg;
    logic        lock_err_reg;
    logic        core_hold_reg;
    logic        cfg_write_reg;
    logic [5:0]  cfg_address_reg;
    logic [31:0] cfg_data_reg;
    logic [15:0] cnt_reg;

    logic        mode_f;
    logic        locked_s;
    logic        wr_done;

    sync_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_mode_filter (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (mode_req),
        .dout    (mode_f)
    );

    // Lock flag only needs synchronizing; the settle window does the debouncing.
    sync_filter #(.STABLE_CYCLES(0)) u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (pll_locked),
        .dout    (locked_s)
    );

    // A write is accepted on any edge where it is presented without waitrequest.
    assign wr_done = cfg_write_reg && !cfg_waitrequest;

    // Sequencer: the bus outputs are loaded one state ahead so they stay stable while waitrequest stalls a write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            target_reg      <= 1'b0;
            applied_reg     <= 1'b0;
            lock_err_reg    <= 1'b0;
            core_hold_reg   <= 1'b0;
            cfg_write_reg   <= 1'b0;
            cfg_address_reg <= 6'd0;
            cfg_data_reg    <= 32'd0;
            cnt_reg         <= 16'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (mode_f != applied_reg) begin
                        target_reg      <= mode_f;
                        state_reg       <= WR_MODE;
                        cfg_write_reg   <= 1'b1;
                        cfg_address_reg <= REG_MODE;
                        cfg_data_reg    <= MODE_WAITREQ;
                        core_hold_reg   <= 1'b1;
                    end
                end
                WR_MODE: begin
                    if (wr_done) begin
                        state_reg       <= WR_K;
                        cfg_address_reg <= REG_K;
                        cfg_data_reg    <= k_for_mode(target_reg, K_NATIVE, K_OVERCLK);
                    end
                end
                WR_K: begin
                    if (wr_done) begin
                        state_reg       <= WR_START;
                        cfg_address_reg <= REG_START;
                        cfg_data_reg    <= 32'd0;
                    end
                end
                WR_START: begin
                    if (wr_done) begin
                        state_reg       <= WAIT_LOCK;
                        cfg_write_reg   <= 1'b0;
                        cfg_address_reg <= 6'd0;
                        cfg_data_reg    <= 32'd0;
                        applied_reg     <= target_reg;
                        cnt_reg         <= 16'd0;
                    end
                end
                WAIT_LOCK: begin
                    // Never wraps: the timeout exit fires before the counter can overflow.
                    cnt_reg <= cnt_reg + 16'd1;
                    if (cnt_reg >= SETTLE_C && locked_s) begin
                        lock_err_reg  <= 1'b0;
                        core_hold_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end else if (cnt_reg == TIMEOUT_C) begin
                        lock_err_reg  <= 1'b1;
                        core_hold_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    cfg_write_reg <= 1'b0;
                    core_hold_reg <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_write    = cfg_write_reg;
    assign cfg_address  = cfg_address_reg;
    assign cfg_data     = cfg_data_reg;
    assign core_hold    = core_hold_reg;
    assign applied_mode = applied_reg;
    assign lock_err     = lock_err_reg;
    assign busy         = core_hold_reg | (mode_f != applied_reg);

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Bench for pll_reconfig_seq: a transaction-level model (pending-write queue,
// relock timer, sample-history filter) checked on every falling edge, plus
// directed scenarios with hand-computed latencies and write contents.
module tb_pll_reconfig_seq;

    localparam int          STABLE  = 2;
    localparam int          SETTLE  = 16;
    localparam int          TIMEOUT = 300;
    localparam logic [31:0] KN      = 32'd2748778984;
    localparam logic [31:0] KO      = 32'd3221912667;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mode_req = 1'b0;
    logic        pll_locked = 1'b1;
    logic        cfg_waitrequest = 1'b0;
    logic        cfg_write;
    logic [5:0]  cfg_address;
    logic [31:0] cfg_data;
    logic        busy;
    logic        core_hold;
    logic        applied_mode;
    logic        lock_err;

    pll_reconfig_seq #(
        .K_NATIVE      (KN),
        .K_OVERCLK     (KO),
        .STABLE_CYCLES (STABLE),
        .SETTLE_CYCLES (SETTLE),
        .LOCK_TIMEOUT  (TIMEOUT)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .mode_req        (mode_req),
        .pll_locked      (pll_locked),
        .cfg_waitrequest (cfg_waitrequest),
        .cfg_write       (cfg_write),
        .cfg_address     (cfg_address),
        .cfg_data        (cfg_data),
        .busy            (busy),
        .core_hold       (core_hold),
        .applied_mode    (applied_mode),
        .lock_err        (lock_err)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // ---------------- model state ----------------
    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t  exp_q[$];
    wr_t  obs_q[$];
    int   obs_cyc[$];
    int   rise_cyc[$];
    logic mh [0:15];
    logic lh [0:1];
    logic m_mode_f = 1'b0;
    logic m_applied = 1'b0;
    logic m_target = 1'b0;
    logic m_hold = 1'b0;
    logic m_err = 1'b0;
    logic m_wait = 1'b0;
    int   m_t = 0;
    logic prev_wr = 1'b0;
    logic prev_err = 1'b0;
    logic ew;
    int   k_hold_cycles = 0;
    int   err_rise_cyc = -1;

    task automatic m_reset();
        for (int i = 0; i < 16; i++) mh[i] = 1'b0;
        lh[0] = 1'b0;
        lh[1] = 1'b0;
        m_mode_f  = 1'b0;
        m_applied = 1'b0;
        m_target  = 1'b0;
        m_hold    = 1'b0;
        m_err     = 1'b0;
        m_wait    = 1'b0;
        m_t       = 0;
        exp_q.delete();
    endtask

    // Advance the model across one rising edge, using the inputs that edge samples.
    task automatic m_step();
        logic same;
        wr_t  w;
        if (exp_q.size() != 0) begin
            if (!cfg_waitrequest) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) begin
                    m_applied = m_target;
                    m_wait    = 1'b1;
                    m_t       = 0;
                end
            end
        end else if (m_wait) begin
            if (m_t >= SETTLE && lh[1]) begin
                m_wait = 1'b0; m_hold = 1'b0; m_err = 1'b0;
            end else if (m_t == TIMEOUT) begin
                m_wait = 1'b0; m_hold = 1'b0; m_err = 1'b1;
            end else begin
                m_t++;
            end
        end else if (m_mode_f != m_applied) begin
            m_target = m_mode_f;
            m_hold   = 1'b1;
            w.addr = 6'd0; w.data = 32'd0;                 exp_q.push_back(w);
            w.addr = 6'd7; w.data = m_mode_f ? KO : KN;    exp_q.push_back(w);
            w.addr = 6'd2; w.data = 32'd0;                 exp_q.push_back(w);
        end
        // Filtered mode follows the synchronized sample once the last STABLE samples agree.
        same = 1'b1;
        for (int i = 2; i <= STABLE; i++) if (mh[i] !== mh[1]) same = 1'b0;
        if (same) m_mode_f = mh[1];
        for (int i = 15; i > 0; i--) mh[i] = mh[i-1];
        mh[0] = mode_req;
        lh[1] = lh[0];
        lh[0] = pll_locked;
    endtask

    // Compare process: DUT outputs against the model every cycle, then advance the model.
    always @(negedge clk) begin
        if (!reset_n) m_reset();
        ew = (exp_q.size() != 0);
        chk("cfg_write", 32'(cfg_write), 32'(ew));
        if (ew) begin
            chk("cfg_address", 32'(cfg_address), 32'(exp_q[0].addr));
            chk("cfg_data", cfg_data, exp_q[0].data);
        end
        chk("core_hold", 32'(core_hold), 32'(m_hold));
        chk("applied_mode", 32'(applied_mode), 32'(m_applied));
        chk("lock_err", 32'(lock_err), 32'(m_err));
        chk("busy", 32'(busy), 32'(m_hold | (m_mode_f != m_applied)));

        if (reset_n && cfg_write && !cfg_waitrequest) begin
            wr_t o;
            o.addr = cfg_address;
            o.data = cfg_data;
            obs_q.push_back(o);
            obs_cyc.push_back(cyc);
            $display("write addr=%0d data=%0d cycle=%0d", cfg_address, cfg_data, cyc);
        end
        if (cfg_write && !prev_wr) rise_cyc.push_back(cyc);
        if (cfg_write && cfg_address == 6'd7) k_hold_cycles++;
        if (lock_err && !prev_err) err_rise_cyc = cyc;
        prev_wr  = cfg_write;
        prev_err = lock_err;

        if (reset_n) m_step();
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        obs_q.delete();
        obs_cyc.delete();
        rise_cyc.delete();
        k_hold_cycles = 0;
    endtask

    // Check a logged three-write sequence against literal contents and spacing.
    task automatic chk_seq(input string tag, input logic [31:0] kexp, input int gap_k);
        chk({tag, "_nwrites"}, 32'(obs_q.size()), 32'd3);
        if (obs_q.size() == 3) begin
            chk({tag, "_a0"}, 32'(obs_q[0].addr), 32'd0);
            chk({tag, "_d0"}, obs_q[0].data, 32'd0);
            chk({tag, "_a1"}, 32'(obs_q[1].addr), 32'd7);
            chk({tag, "_d1"}, obs_q[1].data, kexp);
            chk({tag, "_a2"}, 32'(obs_q[2].addr), 32'd2);
            chk({tag, "_d2"}, obs_q[2].data, 32'd0);
            chk({tag, "_gap01"}, 32'(obs_cyc[1] - obs_cyc[0]), 32'(gap_k));
            chk({tag, "_gap12"}, 32'(obs_cyc[2] - obs_cyc[1]), 32'd1);
        end
    endtask

    initial begin
        int c0;
        reset_n = 1'b0; mode_req = 1'b0; pll_locked = 1'b1; cfg_waitrequest = 1'b0;
        step(5);
        reset_n = 1'b1;

        // Idle after reset with mode 0: nothing happens for 1000 cycles.
        step(1000);
        chk("idle_nwrites", 32'(obs_q.size()), 32'd0);
        chk("idle_nrises", 32'(rise_cyc.size()), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_core_hold", 32'(core_hold), 32'd0);
        chk("idle_applied", 32'(applied_mode), 32'd0);

        // 0 -> 1, lock drops and returns 40 cycles later.
        clear_logs();
        mode_req = 1'b1; pll_locked = 1'b0; c0 = cyc;
        step(40); pll_locked = 1'b1;
        step(60);
        chk("t2_first_write_latency", 32'(rise_cyc.size() > 0 ? rise_cyc[0] - c0 : -1), 32'd5);
        chk_seq("t2", KO, 1);
        chk("t2_applied", 32'(applied_mode), 32'd1);
        chk("t2_core_hold", 32'(core_hold), 32'd0);

        // 1 -> 0 with waitrequest stalling the K write for 3 cycles.
        clear_logs();
        mode_req = 1'b0; pll_locked = 1'b0; c0 = cyc;
        step(6); cfg_waitrequest = 1'b1;
        step(3); cfg_waitrequest = 1'b0;
        step(31); pll_locked = 1'b1;
        step(60);
        chk_seq("t3", KN, 4);
        chk("t3_k_hold_cycles", 32'(k_hold_cycles), 32'd4);
        chk("t3_applied", 32'(applied_mode), 32'd0);

        // 0 -> 1 with lock never returning: timeout.
        clear_logs();
        mode_req = 1'b1; pll_locked = 1'b0; c0 = cyc; err_rise_cyc = -1;
        step(TIMEOUT + 40);
        chk("t4_lock_err", 32'(lock_err), 32'd1);
        chk("t4_err_latency", 32'(err_rise_cyc - c0), 32'(TIMEOUT + 9));
        chk("t4_core_hold", 32'(core_hold), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_applied", 32'(applied_mode), 32'd1);

        // Successful 1 -> 0 sequence clears the sticky error.
        clear_logs();
        mode_req = 1'b0; pll_locked = 1'b1;
        step(60);
        chk_seq("t4b", KN, 1);
        chk("t4b_lock_err", 32'(lock_err), 32'd0);

        // Mode flips back during WAIT_LOCK: two full sequences.
        clear_logs();
        mode_req = 1'b1; c0 = cyc;
        step(12); mode_req = 1'b0;
        step(80);
        chk("t5_nwrites", 32'(obs_q.size()), 32'd6);
        if (obs_q.size() == 6) begin
            chk("t5_k1", obs_q[1].data, KO);
            chk("t5_k2", obs_q[4].data, KN);
        end
        chk("t5_second_start", 32'(rise_cyc.size() > 1 ? rise_cyc[1] - c0 : -1), 32'd26);
        chk("t5_applied", 32'(applied_mode), 32'd0);

        // One-cycle glitch: filtered away.
        clear_logs();
        mode_req = 1'b1; step(1); mode_req = 1'b0;
        step(40);
        chk("glitch_nwrites", 32'(obs_q.size()), 32'd0);
        chk("glitch_busy", 32'(busy), 32'd0);

        // Reset asserted while the K write is on the bus.
        clear_logs();
        mode_req = 1'b1;
        step(60);
        chk("t6_applied_before", 32'(applied_mode), 32'd1);
        clear_logs();
        mode_req = 1'b0;
        step(6); #4;
        chk("t6_in_wr_k", 32'(cfg_address), 32'd7);
        reset_n = 1'b0; #1;
        chk("t6_rst_write", 32'(cfg_write), 32'd0);
        chk("t6_rst_core_hold", 32'(core_hold), 32'd0);
        chk("t6_rst_applied", 32'(applied_mode), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_addr", 32'(cfg_address), 32'd0);
        step(3); reset_n = 1'b1;
        step(50);
        chk("t6_nwrites", 32'(obs_q.size()), 32'd1);
        chk("t6_nrises", 32'(rise_cyc.size()), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pll_reconfig_seq.md
# pll_reconfig_seq

Sequencer for the video PLL's Avalon-MM reconfiguration port. It lets the OSD "Game Speed" option switch the core clock between native and 60 Hz-overclock rates at run time. It runs on the 50 MHz management clock, filters the asynchronous mode request and issues the three-write reconfiguration sequence (mode, fractional K, start). While the PLL relocks it holds the game core in reset and reports lock failure.

## Interface

Parameters:
- K_NATIVE, 32'd2748778984: fractional-K word written for mode 0 (native timing).
- K_OVERCLK, 32'd3221912667: fractional-K word written for mode 1 (60 Hz).
- STABLE_CYCLES, 2: consecutive unchanged synchronized samples required to accept a mode change (1..15).
- SETTLE_CYCLES, 16: minimum cycles after the start write before `pll_locked` is trusted.
- LOCK_TIMEOUT, 65535: cycles after the start write before a lock failure is declared (fits 16 bits; > SETTLE_CYCLES).

Ports:
- clk  in  1  management clock (CLK_50M domain); all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset; synchronous deassertion is the integrator's job.
- mode_req  in  1  requested mode (0 native, 1 overclock); asynchronous (status bit from clk_sys domain).
- pll_locked  in  1  lock flag of the reconfigured PLL; asynchronous.
- cfg_waitrequest  in  1  Avalon-MM waitrequest from the reconfig controller.
- cfg_write  out  1  Avalon-MM write strobe.
- cfg_address  out  6  register address.
- cfg_data  out  32  write data.
- busy  out  1  sequence in progress, or accepted mode differs from applied mode.
- core_hold  out  1  high from the first write until lock or timeout; OR into the core reset.
- applied_mode  out  1  mode last written to the PLL.
- lock_err  out  1  sticky; set on timeout, cleared when the next sequence reaches lock.

## Operation

- Input conditioning:
  - `mode_req` and `pll_locked` each pass through a 2-flop synchronizer.
  - The synchronized mode is filtered: `mode_f` takes the synchronized value after it has matched its previous sample for STABLE_CYCLES consecutive cycles.
  - `mode_f` resets to 0.
- States and transitions:
  - IDLE: if `mode_f != applied_mode`, latch `target <= mode_f` and go to WR_MODE.
  - WR_MODE: address 0, data 0 (waitrequest mode). Go to WR_K.
  - WR_K: address 7, data `target ? K_OVERCLK : K_NATIVE`. Go to WR_START.
  - WR_START: address 2, data 0. On completion, `applied_mode <= target`, clear the counter, go to WAIT_LOCK.
  - WAIT_LOCK: the counter increments each cycle.
    - If `cnt >= SETTLE_CYCLES` and synchronized locked = 1: clear `lock_err`, go to IDLE.
    - Else if `cnt == LOCK_TIMEOUT`: set `lock_err`, go to IDLE.
- Write handshake:
  - In each WR_* state, `cfg_write` = 1 and address/data are held stable.
  - A transfer completes on a cycle with `cfg_write=1 && !cfg_waitrequest`; the state advances on that edge.
  - `cfg_write` is deasserted in every non-WR state.
- A mode change during a sequence is not aborted. It is re-evaluated in IDLE, and a new sequence starts the cycle after return if `mode_f != applied_mode`.
- A toggle and back within the filter window produces no sequence.
- `core_hold` = state ≠ IDLE. `busy` = `core_hold` OR (`mode_f != applied_mode`).
- Reset values: state IDLE, `cfg_write` 0, `cfg_address` 0, `cfg_data` 0, `busy` 0, `core_hold` 0, `applied_mode` 0, `lock_err` 0, counters 0. PLL power-up configuration equals mode 0, so no sequence is issued after reset while `mode_req=0`.
- Reset asserted mid-sequence: all outputs go to their reset values immediately, including dropping `cfg_write`. The reconfig controller must share `reset_n`.

## Timing

- Mode edge to first write: 2 sync cycles + STABLE_CYCLES filter cycles + 1 IDLE decision cycle = 5 cycles at defaults.
- With `cfg_waitrequest` held 0, the writes occupy 3 consecutive cycles (addresses 0, 7, 2). Each waitrequest cycle adds one cycle to the current write.
- `core_hold` rises with the first `cfg_write` and falls on the same edge that enters IDLE.
- Lock exit is no earlier than SETTLE_CYCLES + 1 cycles after the start write completes, plus 2 cycles of locked-synchronizer delay.
- Counter width is 16 bits; it does not wrap, because WAIT_LOCK exits at LOCK_TIMEOUT.

## Structure

- `pll_reconfig_pkg`:
  - state enum (IDLE, WR_MODE, WR_K, WR_START, WAIT_LOCK);
  - register address localparams: REG_MODE=0, REG_START=2, REG_K=7;
  - default K constants.
- Sub-module `sync_filter`, instantiated twice: 2-flop synchronizer plus a STABLE_CYCLES stability filter, with the filter bypassed (STABLE_CYCLES=0) for `pll_locked`.
- The top holds the FSM, write mux, lock counter and flags.

## Test plan

- Reset release with `mode_req=0` and locked=1 → no `cfg_write` for 1000 cycles; all outputs 0.
- `mode_req` 0→1, waitrequest 0, locked drops then returns after 40 cycles → writes (0,0), (7,3221912667), (2,0) on consecutive cycles. First write occurs 5 cycles after the edge. `applied_mode=1`; `core_hold` falls after lock.
- Same as the previous case, with waitrequest held high for 3 cycles on the K write → address 7 and its data stay stable for 4 cycles; sequence order is unchanged.
- `pll_locked` held 0 after the start write → `lock_err` rises at LOCK_TIMEOUT, `core_hold` falls, FSM is back in IDLE. A following successful 1→0 sequence clears `lock_err`.
- `mode_req` toggled 1→0 during WAIT_LOCK → the first sequence completes, then a second sequence writes K_NATIVE. A 1-cycle `mode_req` glitch produces no write.
- `reset_n` asserted during WR_K → `cfg_write`, `core_hold` and `applied_mode` are 0 within the same cycle, asynchronously.
